msg_packet_arbiter: RTL and testbench

MSG_PACKET_ARBITER -- requirements
Module: msg_packet_arbiter

---
 rtl/msg_packet_arbiter.sv | 151 +++++++++++++++
 tb/tb_msg_packet_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/msg_packet_arbiter.sv
// Round-robin packet arbiter: grants one stream per packet and forwards its words.
// Optional grant watchdog enabled by defining MSG_ARB_TIMEOUT_EN.
module msg_packet_arbiter #(
  parameter int N_STREAMS        = 2,
  parameter int WDTH             = 32,
  parameter int MSG_LENGTH_WIDTH = 8,
  parameter int TIMEOUT          = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_STREAMS-1:0]                  in_req,
  input  logic [N_STREAMS*MSG_LENGTH_WIDTH-1:0] in_length,
  input  logic [N_STREAMS*WDTH-1:0]             in_data,
  input  logic [N_STREAMS-1:0]                  in_nd,
  output logic [N_STREAMS-1:0]                  out_grant,
  output logic [WDTH-1:0]                       out_data,
  output logic                                  out_nd,
  output logic                                  error
);

  localparam int PW = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                      state, state_nxt;
  logic [PW-1:0]               rr_ptr, rr_nxt, gidx, gidx_nxt, sel;
  logic [MSG_LENGTH_WIDTH-1:0] len_q, len_nxt, cnt, cnt_nxt, sel_len, cnt_inc;
  logic [N_STREAMS-1:0]        grant_nxt;
  logic [WDTH-1:0]             data_nxt;
  logic                        nd_nxt, err_nxt, found, stray, gnd;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int off = 0; off < N_STREAMS; off++) begin
      idx = (int'(rr_ptr) + off) % N_STREAMS;
      if (!found && in_req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign sel_len = in_length[sel*MSG_LENGTH_WIDTH +: MSG_LENGTH_WIDTH];
  assign cnt_inc = cnt + 1'b1;
  assign gnd     = (state == ACTIVE) && in_nd[gidx];
  // out_grant is all-zero in IDLE, so every strobe there is stray.
  assign stray   = |(in_nd & ~out_grant);

`ifdef MSG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt, to_nxt;
`endif

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    gidx_nxt  = gidx;
    len_nxt   = len_q;
    cnt_nxt   = cnt;
    grant_nxt = out_grant;
    data_nxt  = out_data;
    nd_nxt    = 1'b0;
    err_nxt   = error | stray;
`ifdef MSG_ARB_TIMEOUT_EN
    to_nxt    = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          rr_nxt = (sel == PW'(N_STREAMS - 1)) ? '0 : sel + 1'b1;
          if (sel_len == '0) begin
            err_nxt = 1'b1;
          end else begin
            grant_nxt      = '0;
            grant_nxt[sel] = 1'b1;
            gidx_nxt       = sel;
            len_nxt        = sel_len;
            cnt_nxt        = '0;
            state_nxt      = ACTIVE;
`ifdef MSG_ARB_TIMEOUT_EN
            to_nxt         = '0;
`endif
          end
        end
      end
      ACTIVE: begin
        if (gnd) begin
          nd_nxt   = 1'b1;
          data_nxt = in_data[gidx*WDTH +: WDTH];
          cnt_nxt  = cnt_inc;
`ifdef MSG_ARB_TIMEOUT_EN
          to_nxt   = '0;
`endif
          if (cnt_inc == len_q) begin
            grant_nxt = '0;
            state_nxt = IDLE;
          end
        end
`ifdef MSG_ARB_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT - 1)) begin
          grant_nxt = '0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      len_q     <= '0;
      cnt       <= '0;
      out_grant <= '0;
      out_data  <= '0;
      out_nd    <= 1'b0;
      error     <= 1'b0;
`ifdef MSG_ARB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      gidx      <= gidx_nxt;
      len_q     <= len_nxt;
      cnt       <= cnt_nxt;
      out_grant <= grant_nxt;
      out_data  <= data_nxt;
      out_nd    <= nd_nxt;
      error     <= err_nxt;
`ifdef MSG_ARB_TIMEOUT_EN
      to_cnt    <= to_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_msg_packet_arbiter.sv
// Self-checking bench for msg_packet_arbiter: vector table, corner sequences, random vs model.
module tb_msg_packet_arbiter;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int LW = 8;
  localparam int TO = 8;

  logic           clk = 0;
  logic           reset = 0;
  logic [N-1:0]   in_req = '0;
  logic [N*LW-1:0] in_length = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_nd = '0;
  logic [N-1:0]   out_grant;
  logic [W-1:0]   out_data;
  logic           out_nd;
  logic           error;

  int checks = 0;
  int errors = 0;

  msg_packet_arbiter #(.N_STREAMS(N), .WDTH(W), .MSG_LENGTH_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_length(in_length), .in_data(in_data),
    .in_nd(in_nd), .out_grant(out_grant), .out_data(out_data), .out_nd(out_nd), .error(error)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the output, how many words remain, who is next in line.
  bit        m_busy;
  int        m_owner, m_rem, m_prio, m_idle;
  bit        m_err, m_nd;
  bit [31:0] m_data;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_rem = 0; m_prio = 0; m_idle = 0;
    m_err = 0; m_nd = 0; m_data = 0;
  endtask

  task automatic model_edge();
    bit found;
    int s;
    for (int i = 0; i < N; i++)
      if (in_nd[i] && !(m_busy && m_owner == i)) m_err = 1;
    m_nd = 0;
    if (m_busy) begin
      if (in_nd[m_owner]) begin
        m_nd = 1;
        m_data = in_data[m_owner*W +: W];
        m_rem--;
        m_idle = 0;
        if (m_rem == 0) m_busy = 0;
      end else begin
        m_idle++;
`ifdef MSG_ARB_TIMEOUT_EN
        if (m_idle == TO) begin m_busy = 0; m_err = 1; end
`endif
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        s = (m_prio + k) % N;
        if (!found && in_req[s]) begin
          found = 1;
          m_prio = (s + 1) % N;
          if (in_length[s*LW +: LW] == 0) m_err = 1;
          else begin m_busy = 1; m_owner = s; m_rem = int'(in_length[s*LW +: LW]); m_idle = 0; end
        end
      end
    end
  endtask

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [1:0] req, input logic [7:0] l0, input logic [7:0] l1,
                      input logic [1:0] nd, input logic [31:0] d0, input logic [31:0] d1);
    in_req = req; in_length = {l1, l0}; in_nd = nd; in_data = {d1, d0};
    @(posedge clk);
    model_edge();
    #1;
    chk("model_grant", 64'(out_grant), 64'(m_grant()));
    chk("model_nd",    64'(out_nd),    64'(m_nd));
    chk("model_data",  64'(out_data),  64'(m_data));
    chk("model_error", 64'(error),     64'(m_err));
  endtask

  task automatic do_reset();
    in_req = '0; in_nd = '0; in_length = '0; in_data = '0;
    @(negedge clk);
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  l0, l1;
    logic [1:0]  nd;
    logic [31:0] d0, d1;
    logic [1:0]  g;
    logic        ond;
    logic [31:0] od;
    logic        err;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Single packet on stream 0, then contention with both lengths 2.
    tbl[0]  = '{2'b01, 8'd3, 8'd0, 2'b00, 32'hDEAD, 32'hBEEF, 2'b01, 1'b0, 32'h0,  1'b0};
    tbl[1]  = '{2'b01, 8'd3, 8'd0, 2'b01, 32'hA,    32'hBEEF, 2'b01, 1'b1, 32'hA,  1'b0};
    tbl[2]  = '{2'b01, 8'd3, 8'd0, 2'b01, 32'hB,    32'hBEEF, 2'b01, 1'b1, 32'hB,  1'b0};
    tbl[3]  = '{2'b00, 8'd3, 8'd0, 2'b01, 32'hC,    32'hBEEF, 2'b00, 1'b1, 32'hC,  1'b0};
    tbl[4]  = '{2'b00, 8'd3, 8'd0, 2'b00, 32'hDEAD, 32'hBEEF, 2'b00, 1'b0, 32'hC,  1'b0};
    tbl[5]  = '{2'b11, 8'd2, 8'd2, 2'b00, 32'hDEAD, 32'hBEEF, 2'b10, 1'b0, 32'hC,  1'b0};
    tbl[6]  = '{2'b11, 8'd2, 8'd2, 2'b10, 32'hDEAD, 32'h11,   2'b10, 1'b1, 32'h11, 1'b0};
    tbl[7]  = '{2'b11, 8'd2, 8'd2, 2'b10, 32'hDEAD, 32'h12,   2'b00, 1'b1, 32'h12, 1'b0};
    tbl[8]  = '{2'b11, 8'd2, 8'd2, 2'b00, 32'hDEAD, 32'hBEEF, 2'b01, 1'b0, 32'h12, 1'b0};
    tbl[9]  = '{2'b11, 8'd2, 8'd2, 2'b01, 32'h21,   32'hBEEF, 2'b01, 1'b1, 32'h21, 1'b0};
    tbl[10] = '{2'b11, 8'd2, 8'd2, 2'b01, 32'h22,   32'hBEEF, 2'b00, 1'b1, 32'h22, 1'b0};
    tbl[11] = '{2'b11, 8'd2, 8'd2, 2'b00, 32'hDEAD, 32'hBEEF, 2'b10, 1'b0, 32'h22, 1'b0};
    tbl[12] = '{2'b11, 8'd2, 8'd2, 2'b10, 32'hDEAD, 32'h31,   2'b10, 1'b1, 32'h31, 1'b0};
    tbl[13] = '{2'b11, 8'd2, 8'd2, 2'b10, 32'hDEAD, 32'h32,   2'b00, 1'b1, 32'h32, 1'b0};
    tbl[14] = '{2'b00, 8'd2, 8'd2, 2'b00, 32'hDEAD, 32'hBEEF, 2'b00, 1'b0, 32'h32, 1'b0};

    model_reset();
    reset = 1;
    #12;
    chk("reset_grant", 64'(out_grant), 64'h0);
    chk("reset_nd",    64'(out_nd),    64'h0);
    chk("reset_data",  64'(out_data),  64'h0);
    chk("reset_error", 64'(error),     64'h0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req, tbl[i].l0, tbl[i].l1, tbl[i].nd, tbl[i].d0, tbl[i].d1);
      chk($sformatf("tbl%0d_grant", i), 64'(out_grant), 64'(tbl[i].g));
      chk($sformatf("tbl%0d_nd", i),    64'(out_nd),    64'(tbl[i].ond));
      chk($sformatf("tbl%0d_data", i),  64'(out_data),  64'(tbl[i].od));
      chk($sformatf("tbl%0d_error", i), 64'(error),     64'(tbl[i].err));
    end

    // Stray strobe from the non-granted stream.
    do_reset();
    step(2'b01, 8'd2, 8'd0, 2'b00, 32'h0, 32'h0);
    step(2'b01, 8'd2, 8'd0, 2'b10, 32'h0, 32'h55);
    chk("stray_nd",  64'(out_nd), 64'h0);
    chk("stray_err", 64'(error),  64'h1);
    step(2'b01, 8'd2, 8'd0, 2'b01, 32'h1, 32'h0);
    step(2'b00, 8'd2, 8'd0, 2'b01, 32'h2, 32'h0);
    step(2'b00, 8'd0, 8'd0, 2'b00, 32'h0, 32'h0);
    chk("stray_sticky", 64'(error), 64'h1);

    // Zero length on stream 0, then stream 1 wins the next arbitration.
    do_reset();
    step(2'b01, 8'd0, 8'd0, 2'b00, 32'h0, 32'h0);
    chk("zlen_grant", 64'(out_grant), 64'h0);
    chk("zlen_err",   64'(error),     64'h1);
    step(2'b11, 8'd0, 8'd2, 2'b00, 32'h0, 32'h0);
    chk("zlen_next", 64'(out_grant), 64'h2);

    // Reset mid-packet after two words (with error already set).
    do_reset();
    step(2'b01, 8'd4, 8'd0, 2'b00, 32'h0, 32'h0);
    step(2'b01, 8'd4, 8'd0, 2'b01, 32'h7, 32'h0);
    step(2'b01, 8'd4, 8'd0, 2'b11, 32'h8, 32'h9);
    #2;
    reset = 1;
    #1;
    chk("rst_mid_grant", 64'(out_grant), 64'h0);
    chk("rst_mid_nd",    64'(out_nd),    64'h0);
    chk("rst_mid_err",   64'(error),     64'h0);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 8'd0, 8'd0, 2'b00, 32'h0, 32'h0);
      chk("rst_no_residual", 64'(out_nd), 64'h0);
    end

    // Watchdog (or grant persistence when the watchdog is not built).
    do_reset();
    step(2'b01, 8'd3, 8'd0, 2'b00, 32'h0, 32'h0);
`ifdef MSG_ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) step(2'b00, 8'd0, 8'd0, 2'b00, 32'h0, 32'h0);
    chk("wd_before", 64'(out_grant), 64'h1);
    step(2'b00, 8'd0, 8'd0, 2'b00, 32'h0, 32'h0);
    chk("wd_grant", 64'(out_grant), 64'h0);
    chk("wd_err",   64'(error),     64'h1);
`else
    for (int i = 0; i < 100; i++) step(2'b00, 8'd0, 8'd0, 2'b00, 32'h0, 32'h0);
    chk("persist_grant", 64'(out_grant), 64'h1);
    chk("persist_err",   64'(error),     64'h0);
`endif

    // Random traffic against the model.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        logic [1:0] rq, nd;
        logic [7:0] l0, l1;
        rq = 2'($urandom_range(0, 3));
        l0 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
        l1 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
        nd = '0;
        if (m_busy && $urandom_range(0, 3) != 0) nd[m_owner] = 1'b1;
        if ($urandom_range(0, 31) == 0) nd = nd | 2'($urandom_range(0, 3));
        step(rq, l0, l1, nd, $urandom, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
